// File: rtl/wb_interconnect_to_pkg.sv
// wb_interconnect_to_pkg: FSM state encodings, fault codes and sizing helpers for the WB interconnect.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package wb_interconnect_to_pkg;

  // FSM states kept as plain 2-bit constants so older tooling and waveform
  // decoders that expect raw codes keep working.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Fault codes reported on fault_code_o.
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_MISS    = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
  localparam logic [1:0] FAULT_SLV_ERR = 2'b11;

  // Timer must count 0..TIMEOUT-1; a disabled timeout still needs a 1-bit vector.
  function automatic int timer_width(input int timeout);
    return (timeout <= 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_interconnect_to_if.sv
// wb_interconnect_to_if: bundles the upstream master bus and the downstream N-slave bus of the interconnect.
// Latency: n/a (wiring only).
// Backpressure: n/a (wiring only); ack/err from slaves stall the interconnect until returned.
// Modports: slave  = the interconnect's view (it is the Wishbone slave of the upstream master);
//           master = the surrounding environment's view (upstream master plus the downstream slaves).
interface wb_interconnect_to_if #(
  parameter int NUM_SLAVES = 24
);
  // upstream master side
  logic                    wbm_cyc_i;
  logic                    wbm_stb_i;
  logic                    wbm_we_i;
  logic [3:0]              wbm_sel_i;
  logic [31:0]             wbm_adr_i;
  logic [31:0]             wbm_dat_i;
  logic [31:0]             wbm_dat_o;
  logic                    wbm_ack_o;
  logic                    wbm_err_o;
  // downstream slave side
  logic [NUM_SLAVES-1:0]   wbs_cyc_o;
  logic [NUM_SLAVES-1:0]   wbs_stb_o;
  logic                    wbs_we_o;
  logic [3:0]              wbs_sel_o;
  logic [31:0]             wbs_adr_o;
  logic [31:0]             wbs_dat_o;
  logic [32*NUM_SLAVES-1:0] wbs_dat_i;
  logic [NUM_SLAVES-1:0]   wbs_ack_i;
  logic [NUM_SLAVES-1:0]   wbs_err_i;

  modport slave (
    input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o,
    output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i
  );

  modport master (
    output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o,
    input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i
  );

endinterface

// File: rtl/wb_interconnect_to_addr_decode.sv
// wb_interconnect_to_addr_decode: address-window hit vector, lowest-index priority select and base mux.
// Latency: combinational.
// Backpressure: none.
// Ports: adr in; hit_any, one-hot hit_sel and the matching window base hit_base out.
module wb_interconnect_to_addr_decode #(
  parameter int                       NUM_SLAVES = 24,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_ADDR = '0,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_HIGH = '0
) (
  input  logic [31:0]           adr,
  output logic                  hit_any,
  output logic [NUM_SLAVES-1:0] hit_sel,
  output logic [31:0]           hit_base
);

  logic [NUM_SLAVES-1:0] hit_vec;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit_vec[i] = (adr >= SLAVE_ADDR[32*i +: 32]) && (adr <= SLAVE_HIGH[32*i +: 32]);
    end
  end

  // Walk from the top index down so the lowest overlapping window is the last
  // one written and therefore wins.
  always_comb begin
    hit_any  = 1'b0;
    hit_sel  = '0;
    hit_base = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any    = 1'b1;
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
        hit_base   = SLAVE_ADDR[32*i +: 32];
      end
    end
  end

endmodule

// File: rtl/wb_interconnect_to.sv
// wb_interconnect_to: Wishbone 1-to-N interconnect with decode-miss, timeout, slave-error and abort handling.
// Latency: request sampled in IDLE; a slave acking in its first strobed cycle gives wbm_ack_o 3 cycles later.
// Backpressure: one transaction in flight; the master is only sampled in IDLE, slave stalls end at TIMEOUT.
// Ports: wb_clk_i, wb_rst_n_i (async active-low); bus (master + slave Wishbone signals);
//        fault_clr_i clears count/code; fault_adr_o, fault_code_o, fault_cnt_o describe the latest fault.
module wb_interconnect_to
  import wb_interconnect_to_pkg::*;
#(
  parameter int                       NUM_SLAVES    = 24,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_ADDR    = '0,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_HIGH    = '0,
  parameter int                       TIMEOUT       = 1024,
  parameter bit                       ADDR_RELATIVE = 1'b0,
  parameter int                       FAULT_CNT_W   = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  wb_interconnect_to_if.slave    bus,
  input  logic                   fault_clr_i,
  output logic [31:0]            fault_adr_o,
  output logic [1:0]             fault_code_o,
  output logic [FAULT_CNT_W-1:0] fault_cnt_o
);

  localparam int          TW           = timer_width(TIMEOUT);
  localparam int          TIMER_LAST_I = (TIMEOUT <= 0) ? 0 : TIMEOUT - 1;
  localparam logic [TW-1:0] TIMER_LAST = TIMER_LAST_I[TW-1:0];

  logic [1:0]             state;
  logic [31:0]            req_adr;
  logic [NUM_SLAVES-1:0]  slv_sel;
  logic [TW-1:0]          timer;
  logic                   m_ack;
  logic                   m_err;
  logic [31:0]            m_dat;
  logic                   s_we;
  logic [3:0]             s_sel;
  logic [31:0]            s_adr;
  logic [31:0]            s_dat;

  logic                   hit_any;
  logic [NUM_SLAVES-1:0]  hit_sel;
  logic [31:0]            hit_base;
  logic                   sel_ack;
  logic                   sel_err;
  logic [31:0]            sel_dat;
  logic                   timed_out;
  logic                   fault_new;
  logic [1:0]             fault_new_code;

  wb_interconnect_to_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_ADDR (SLAVE_ADDR),
    .SLAVE_HIGH (SLAVE_HIGH)
  ) u_decode (
    .adr      (req_adr),
    .hit_any  (hit_any),
    .hit_sel  (hit_sel),
    .hit_base (hit_base)
  );

  // Only the selected slave's response matters; others may be driving junk.
  assign sel_ack   = |(bus.wbs_ack_i & slv_sel);
  assign sel_err   = |(bus.wbs_err_i & slv_sel);
  assign timed_out = (TIMEOUT > 0) && (timer == TIMER_LAST);

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slv_sel[i]) sel_dat = sel_dat | bus.wbs_dat_i[32*i +: 32];
    end
  end

  // A fault is the transition into RESP with an error. An abort (cyc dropped)
  // outranks every slave response and never logs a fault.
  always_comb begin
    fault_new      = 1'b0;
    fault_new_code = FAULT_NONE;
    if (state == ST_DECODE && !hit_any) begin
      fault_new      = 1'b1;
      fault_new_code = FAULT_MISS;
    end else if (state == ST_WAIT && bus.wbm_cyc_i) begin
      if (sel_err) begin
        fault_new      = 1'b1;
        fault_new_code = FAULT_SLV_ERR;
      end else if (!sel_ack && timed_out) begin
        fault_new      = 1'b1;
        fault_new_code = FAULT_TIMEOUT;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state   <= ST_IDLE;
      req_adr <= '0;
      slv_sel <= '0;
      timer   <= '0;
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      m_dat   <= '0;
      s_we    <= 1'b0;
      s_sel   <= '0;
      s_adr   <= '0;
      s_dat   <= '0;
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
            req_adr <= bus.wbm_adr_i;
            s_adr   <= bus.wbm_adr_i;
            s_we    <= bus.wbm_we_i;
            s_sel   <= bus.wbm_sel_i;
            s_dat   <= bus.wbm_dat_i;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (hit_any) begin
            slv_sel <= hit_sel;
            timer   <= '0;
            if (ADDR_RELATIVE) s_adr <= req_adr - hit_base;
            state   <= ST_WAIT;
          end else begin
            m_err <= 1'b1;
            m_dat <= '0;
            state <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (!bus.wbm_cyc_i) begin
            slv_sel <= '0;
            timer   <= '0;
            s_we    <= 1'b0;
            s_sel   <= '0;
            s_adr   <= '0;
            s_dat   <= '0;
            state   <= ST_IDLE;
          end else if (sel_err || sel_ack || timed_out) begin
            slv_sel <= '0;
            timer   <= '0;
            state   <= ST_RESP;
            if (sel_err || !sel_ack) begin
              m_err <= 1'b1;
              m_dat <= '0;
            end else begin
              m_ack <= 1'b1;
              // write acks leave the last read data visible
              if (!s_we) m_dat <= sel_dat;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_RESP: begin
          s_we  <= 1'b0;
          s_sel <= '0;
          s_adr <= '0;
          s_dat <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A clear coinciding with a new fault is overridden: the new fault becomes count 1.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      fault_adr_o  <= '0;
      fault_code_o <= FAULT_NONE;
      fault_cnt_o  <= '0;
    end else if (fault_new) begin
      fault_adr_o  <= req_adr;
      fault_code_o <= fault_new_code;
      if (fault_clr_i)             fault_cnt_o <= FAULT_CNT_W'(1);
      else if (~&fault_cnt_o)      fault_cnt_o <= fault_cnt_o + FAULT_CNT_W'(1);
    end else if (fault_clr_i) begin
      fault_code_o <= FAULT_NONE;
      fault_cnt_o  <= '0;
    end
  end

  assign bus.wbm_ack_o = m_ack;
  assign bus.wbm_err_o = m_err;
  assign bus.wbm_dat_o = m_dat;
  assign bus.wbs_cyc_o = slv_sel;
  assign bus.wbs_stb_o = slv_sel;
  assign bus.wbs_we_o  = s_we;
  assign bus.wbs_sel_o = s_sel;
  assign bus.wbs_adr_o = s_adr;
  assign bus.wbs_dat_o = s_dat;

endmodule

// File: tb/tb_wb_interconnect_to.sv
// tb_wb_interconnect_to: randomized master/slave stimulus against a transaction-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_wb_interconnect_to;

  localparam int N      = 3;
  localparam int TO     = 16;
  localparam int CW     = 2;
  localparam int CNT_MX = (1 << CW) - 1;
  localparam logic [32*N-1:0] BASES = {32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [32*N-1:0] HIGHS = {32'h0002_FFFF, 32'h0001_FFFF, 32'h0000_FFFF};

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_n_i = 1'b0;
  logic          fault_clr_i = 1'b0;
  logic [31:0]   fault_adr_o;
  logic [1:0]    fault_code_o;
  logic [CW-1:0] fault_cnt_o;

  wb_interconnect_to_if #(.NUM_SLAVES(N)) bus();

  wb_interconnect_to #(
    .NUM_SLAVES    (N),
    .SLAVE_ADDR    (BASES),
    .SLAVE_HIGH    (HIGHS),
    .TIMEOUT       (TO),
    .ADDR_RELATIVE (1'b1),
    .FAULT_CNT_W   (CW)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_n_i   (wb_rst_n_i),
    .bus          (bus),
    .fault_clr_i  (fault_clr_i),
    .fault_adr_o  (fault_adr_o),
    .fault_code_o (fault_code_o),
    .fault_cnt_o  (fault_cnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // address map as the model sees it
  int unsigned win_lo [N] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000};
  int unsigned win_hi [N] = '{32'h0000_FFFF, 32'h0001_FFFF, 32'h0002_FFFF};

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] m_dat  = '0;
  logic [31:0] m_fadr = '0;
  logic [1:0]  m_code = 2'b00;
  int          m_cnt  = 0;

  // slave responder configuration: 0 ack, 1 err, 2 never respond
  int          rsp_kind  = 2;
  int          rsp_delay = 0;
  int          stb_seen  = 0;
  logic [31:0] rsp_dat [N];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slaves answer on the k-th strobed cycle, driven at the falling edge.
  always @(negedge wb_clk_i) begin
    bus.wbs_ack_i = '0;
    bus.wbs_err_i = '0;
    if (bus.wbs_stb_o != '0) begin
      if (rsp_kind == 0 && stb_seen == rsp_delay) bus.wbs_ack_i = bus.wbs_stb_o;
      if (rsp_kind == 1 && stb_seen == rsp_delay) bus.wbs_err_i = bus.wbs_stb_o;
      stb_seen++;
    end else begin
      stb_seen = 0;
    end
  end

  // clr_at: -1 none, -2 on the edge that logs the fault, else cycle index of the pulse
  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] rd,
                         input int kind, input int delay, input int abort_at, input int clr_at_in);
    int s, exp_resp, exp_k, exp_strb, fk, k_end, clr_at;
    int got_resp, got_k, strb;
    logic fault, bus_bad;
    logic [1:0] fcode;
    logic [3:0] sel;
    logic [31:0] wd, got_dat;
    logic [N-1:0] oh;
    s = -1;
    for (int i = N - 1; i >= 0; i--) if (adr >= win_lo[i] && adr <= win_hi[i]) s = i;
    oh = '0;
    if (s >= 0) oh[s] = 1'b1;
    sel = 4'($urandom);
    wd  = $urandom;
    for (int i = 0; i < N; i++) rsp_dat[i] = $urandom;
    if (s >= 0) rsp_dat[s] = rd;
    for (int i = 0; i < N; i++) bus.wbs_dat_i[32*i +: 32] = rsp_dat[i];
    rsp_kind  = (abort_at >= 0) ? 2 : kind;
    rsp_delay = delay;

    fault = 1'b0; fcode = 2'b00; exp_resp = 0; exp_k = -1; exp_strb = 0;
    if (s < 0) begin
      exp_resp = 2; exp_k = 2; fault = 1'b1; fcode = 2'b01;
    end else if (abort_at >= 0) begin
      exp_strb = abort_at - 1;
    end else if (kind == 0) begin
      exp_resp = 1; exp_k = 3 + delay; exp_strb = delay + 1;
    end else if (kind == 1) begin
      exp_resp = 2; exp_k = 3 + delay; exp_strb = delay + 1; fault = 1'b1; fcode = 2'b11;
    end else begin
      exp_resp = 2; exp_k = 2 + TO; exp_strb = TO; fault = 1'b1; fcode = 2'b10;
    end
    fk     = exp_k - 1;
    clr_at = (clr_at_in == -2) ? (fault ? fk : -1) : clr_at_in;
    k_end  = (exp_resp == 0) ? abort_at + 4 : exp_k + 3;

    @(posedge wb_clk_i); #1;
    bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1; bus.wbm_we_i = we;
    bus.wbm_sel_i = sel;  bus.wbm_adr_i = adr;  bus.wbm_dat_i = wd;
    got_resp = 0; got_k = -1; strb = 0; bus_bad = 1'b0; got_dat = '0;
    for (int k = 0; k <= k_end && got_resp == 0; k++) begin
      @(negedge wb_clk_i);
      fault_clr_i = (k == clr_at);
      if (k == abort_at) begin bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0; end
      if (bus.wbs_stb_o != '0) begin
        strb++;
        if (s < 0 || bus.wbs_stb_o != oh || bus.wbs_cyc_o != oh || bus.wbs_we_o != we ||
            bus.wbs_sel_o != sel || bus.wbs_dat_o != wd || bus.wbs_adr_o != adr - win_lo[s])
          bus_bad = 1'b1;
      end
      if (bus.wbm_ack_o || bus.wbm_err_o) begin
        got_resp = (bus.wbm_ack_o ? 1 : 0) + (bus.wbm_err_o ? 2 : 0);
        got_k    = k;
        got_dat  = bus.wbm_dat_o;
        bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
      end
    end
    @(negedge wb_clk_i);
    fault_clr_i = 1'b0;
    bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
    chk_val("resp_one_cycle", {30'd0, bus.wbm_err_o, bus.wbm_ack_o}, 32'd0);

    // model update
    if (exp_resp == 1 && !we) m_dat = rd;
    if (exp_resp == 2) m_dat = '0;
    if (fault) begin
      if (clr_at >= 0 && clr_at < fk) begin m_cnt = 0; m_code = 2'b00; end
      m_cnt  = (clr_at == fk) ? 1 : ((m_cnt < CNT_MX) ? m_cnt + 1 : CNT_MX);
      m_code = fcode;
      m_fadr = adr;
    end else if (clr_at >= 0) begin
      m_cnt = 0; m_code = 2'b00;
    end

    chk_val("resp_kind", got_resp, exp_resp);
    if (exp_resp != 0) chk_val("resp_cycle", got_k, exp_k);
    chk_val("strobe_cycles", strb, exp_strb);
    chk_val("slave_bus_fields", {31'd0, bus_bad}, 32'd0);
    chk_val("rdata", (got_resp != 0) ? got_dat : bus.wbm_dat_o, m_dat);
    chk_val("fault_code", {30'd0, fault_code_o}, {30'd0, m_code});
    chk_val("fault_adr", fault_adr_o, m_fadr);
    chk_val("fault_cnt", {30'd0, fault_cnt_o}, 32'(m_cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r, kd, ab;
    bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0; bus.wbm_we_i = 1'b0;
    bus.wbm_sel_i = '0;   bus.wbm_adr_i = '0;   bus.wbm_dat_i = '0;
    bus.wbs_dat_i = '0;   bus.wbs_ack_i = '0;   bus.wbs_err_i = '0;

    // reset state
    #3;
    chk_val("rst_ack_err", {30'd0, bus.wbm_err_o, bus.wbm_ack_o}, 32'd0);
    chk_val("rst_dat", bus.wbm_dat_o, 32'd0);
    chk_val("rst_stb", {29'd0, bus.wbs_stb_o}, 32'd0);
    chk_val("rst_fault_cnt", {30'd0, fault_cnt_o}, 32'd0);
    repeat (3) @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;

    // 1: read hitting slave 1, ack after 2 extra cycles, relative address 0x4
    run_txn(32'h0001_0004, 1'b0, 32'hCAFE_F00D, 0, 2, -1, -1);
    chk_val("read_data_cafe", bus.wbm_dat_o, 32'hCAFE_F00D);
    // 2: write decode miss
    run_txn(32'h0004_0000, 1'b1, 32'h0, 0, 0, -1, -1);
    chk_val("miss_code", {30'd0, fault_code_o}, 32'd1);
    // 3: slave 2 silent -> timeout
    run_txn(32'h0002_0010, 1'b0, 32'h0, 2, 0, -1, -1);
    chk_val("timeout_code", {30'd0, fault_code_o}, 32'd2);
    // 4: abort mid-WAIT
    run_txn(32'h0000_0100, 1'b0, 32'h0, 2, 0, 5, -1);
    // 5: clear coinciding with a miss, then saturation
    run_txn(32'h0005_0000, 1'b0, 32'h0, 0, 0, -1, -2);
    chk_val("clr_vs_fault_cnt", {30'd0, fault_cnt_o}, 32'd1);
    for (int i = 0; i < 5; i++) run_txn(32'h0080_0000 + 32'(i), 1'b0, 32'h0, 0, 0, -1, -1);
    chk_val("sat_cnt", {30'd0, fault_cnt_o}, 32'd3);
    // idle clear
    run_txn(32'h0001_0020, 1'b0, 32'h1234_5678, 0, 0, -1, 0);

    // 6: reset while slave 2 is strobed
    rsp_kind = 2;
    @(posedge wb_clk_i); #1;
    bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1; bus.wbm_we_i = 1'b0; bus.wbm_adr_i = 32'h0002_0020;
    repeat (4) @(negedge wb_clk_i);
    chk_val("pre_rst_strobe", {29'd0, bus.wbs_stb_o}, 32'd4);
    #2 wb_rst_n_i = 1'b0;
    #1;
    chk_val("arst_cyc_stb", {26'd0, bus.wbs_cyc_o, bus.wbs_stb_o}, 32'd0);
    chk_val("arst_ack_err", {30'd0, bus.wbm_err_o, bus.wbm_ack_o}, 32'd0);
    chk_val("arst_dat", bus.wbm_dat_o, 32'd0);
    chk_val("arst_wbs_adr", bus.wbs_adr_o, 32'd0);
    chk_val("arst_fault", {fault_adr_o[29:0], fault_code_o}, 32'd0);
    chk_val("arst_fault_cnt", {30'd0, fault_cnt_o}, 32'd0);
    bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
    m_dat = '0; m_fadr = '0; m_code = 2'b00; m_cnt = 0;
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    run_txn(32'h0000_0040, 1'b0, 32'hA5A5_0001, 0, 0, -1, -1);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      if (r < 8) begin
        kd = $urandom_range(0, N - 1);
        a  = win_lo[kd] + $urandom_range(0, 16'hFFFF);
      end else begin
        a = $urandom | 32'h0004_0000;
      end
      r  = $urandom_range(0, 9);
      kd = (r < 6) ? 0 : (r < 8) ? 1 : 2;
      ab = (r == 9) ? $urandom_range(2, 12) : -1;
      r  = $urandom_range(0, 5);
      run_txn(a, 1'($urandom), $urandom, kd, $urandom_range(0, 3), ab,
              (r == 0) ? 0 : (r == 1) ? -2 : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
